// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver: 2-FF synchroniser, start-bit validation, mid-bit sampling, byte/framing-error strobes.
// Define UART_RX_MAJORITY_EN to take each sample as a 3-tap majority around the nominal sample count.
module uart_rx_sampler #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] byteFromRx,
  output logic                  rx_new_byte_indicate,
  output logic                  rx_ready,
  output logic                  frame_error
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  // One extra count of headroom so the majority decision at c+1 always fits.
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

`ifdef UART_RX_MAJORITY_EN
  localparam int DECIDE_OFS = 1;
`else
  localparam int DECIDE_OFS = 0;
`endif

  // Restarting the counter at DECIDE_OFS keeps the nominal sample spacing at CLKS_PER_BIT.
  localparam logic [CNT_W-1:0] CNT_RESTART  = CNT_W'(DECIDE_OFS);
  localparam logic [CNT_W-1:0] START_DECIDE = CNT_W'(HALF_BIT - 1 + DECIDE_OFS);
  localparam logic [CNT_W-1:0] BIT_DECIDE   = CNT_W'(CLKS_PER_BIT - 1 + DECIDE_OFS);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} stateT;

  stateT                 state;
  logic [CNT_W-1:0]      bitCnt;
  logic [IDX_W-1:0]      dataIdx;
  logic [DATA_WIDTH-1:0] shiftReg;
  logic                  rxMeta;
  logic                  rxS;
  logic                  sampleBit;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] rxHist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
      rxHist <= 2'b11;
    end else begin
      rxMeta <= rx;
      rxS    <= rxMeta;
      rxHist <= {rxHist[0], rxS};
    end
  end

  // rxHist holds counts c-1 and c when the decision is made at c+1.
  assign sampleBit = (rxHist[1] & rxHist[0]) | (rxHist[1] & rxS) | (rxHist[0] & rxS);
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxS    <= rxMeta;
    end
  end

  assign sampleBit = rxS;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      bitCnt               <= '0;
      dataIdx              <= '0;
      shiftReg             <= '0;
      byteFromRx           <= '0;
      rx_new_byte_indicate <= 1'b0;
      frame_error          <= 1'b0;
      rx_ready             <= 1'b1;
    end else begin
      rx_new_byte_indicate <= 1'b0;
      frame_error          <= 1'b0;
      case (state)
        IDLE: begin
          rx_ready <= 1'b1;
          if (!rxS) begin
            bitCnt   <= '0;
            state    <= START;
            rx_ready <= 1'b0;
          end
        end
        START: begin
          if (bitCnt == START_DECIDE) begin
            if (!sampleBit) begin
              state   <= DATA;
              dataIdx <= '0;
              bitCnt  <= CNT_RESTART;
            end else begin
              state    <= IDLE;
              rx_ready <= 1'b1;
            end
          end else begin
            bitCnt <= bitCnt + CNT_ONE;
          end
        end
        DATA: begin
          if (bitCnt == BIT_DECIDE) begin
            shiftReg[dataIdx] <= sampleBit;
            bitCnt            <= CNT_RESTART;
            if (dataIdx == LAST_IDX) state <= STOP;
            else                     dataIdx <= dataIdx + IDX_ONE;
          end else begin
            bitCnt <= bitCnt + CNT_ONE;
          end
        end
        STOP: begin
          if (bitCnt == BIT_DECIDE) begin
            if (sampleBit) begin
              byteFromRx           <= shiftReg;
              rx_new_byte_indicate <= 1'b1;
              state                <= IDLE;
              rx_ready             <= 1'b1;
            end else begin
              frame_error <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            bitCnt <= bitCnt + CNT_ONE;
          end
        end
        BREAK: begin
          // A held-low line is a break, not data; wait for it to release.
          if (rxS) begin
            state    <= IDLE;
            rx_ready <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          rx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
